// File: rtl/des_pkg.sv
// Shared DES definitions for the iterative round engine: block/subkey widths,
// FSM state type, and the standard E, P and S-box tables.
// Build option DES_ROUND_UNROLL2_EN selects two Feistel rounds per clock.
package des_pkg;

   localparam int DES_ROUNDS  = 16;
   localparam int DES_BLOCK_W = 64;
   localparam int DES_KEY_W   = 48;
   localparam int DES_HALF_W  = 32;

`ifdef DES_ROUND_UNROLL2_EN
   localparam int DES_STEPS = DES_ROUNDS / 2;
`else
   localparam int DES_STEPS = DES_ROUNDS;
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_DONE  = 2'd2
   } des_round_state_t;

   // Entries are 1-based from the MSB, as in the published tables.
   localparam int E_TABLE [48] = '{
      32,  1,  2,  3,  4,  5,
       4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13,
      12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21,
      20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29,
      28, 29, 30, 31, 32,  1
   };

   localparam int P_TABLE [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,
       1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9,
      19, 13, 30,  6, 22, 11,  4, 25
   };

   // Indexed [box][{row, col}], row = {b1, b6}, col = b2..b5.
   localparam int S_TABLE [8][64] = '{
      '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
      '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
      '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
      '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
      '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
      '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
      '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
      '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
   };

endpackage

// File: rtl/des_feistel_f.sv
// DES round function f(R, K): E-expansion, key mix, S1..S8, P permutation.
// Purely combinational; the engine instantiates it once, or twice when
// DES_ROUND_UNROLL2_EN chains two rounds per clock.
module des_feistel_f
   import des_pkg::*;
(
   input  logic [DES_HALF_W-1:0] r_in,
   input  logic [DES_KEY_W-1:0]  k_in,
   output logic [DES_HALF_W-1:0] f_out
);

   logic [DES_KEY_W-1:0]  e_x;
   logic [DES_KEY_W-1:0]  mix;
   logic [DES_HALF_W-1:0] s_out;

   // Table entry n addresses vector bit (width - n), so entry 1 is the MSB.
   for (genvar i = 0; i < 48; i++) begin : g_expand
      assign e_x[47-i] = r_in[32-E_TABLE[i]];
   end

   assign mix = e_x ^ k_in;

   for (genvar b = 0; b < 8; b++) begin : g_sbox
      logic [5:0] six;
      assign six = mix[47-6*b -: 6];
      assign s_out[31-4*b -: 4] = 4'(S_TABLE[b][{six[5], six[0], six[4:1]}]);
   end

   for (genvar i = 0; i < 32; i++) begin : g_perm
      assign f_out[31-i] = s_out[32-P_TABLE[i]];
   end

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES Feistel core between the IP and FP stages. Takes the
// IP-permuted block, runs the 16 rounds with subkeys fetched by round_idx
// from an external key schedule, and presents {R16, L16}.
// Build option DES_ROUND_UNROLL2_EN: two rounds per clock, adds subkey_b.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_IDLE  | in_ready high, waiting for in_valid
//   ST_ROUND | one (or two) Feistel rounds per clock
//   ST_DONE  | out_valid high, result held until out_ready
module des_round_engine
   import des_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DES_BLOCK_W-1:0] data_in,
   input  logic                   decrypt,
   output logic [3:0]             round_idx,
   input  logic [DES_KEY_W-1:0]   subkey,
`ifdef DES_ROUND_UNROLL2_EN
   input  logic [DES_KEY_W-1:0]   subkey_b,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DES_BLOCK_W-1:0] data_out
);

   localparam logic [3:0] CNT_LAST = 4'(DES_STEPS - 1);
   localparam logic [3:0] IDX_STEP = 4'(DES_ROUNDS / DES_STEPS);
   localparam logic [3:0] IDX_TOP  = 4'(DES_ROUNDS - 1);

   des_round_state_t      state_q, state_d;
   logic [DES_HALF_W-1:0] l_q, l_d, r_q, r_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [3:0]            idx_q, idx_d;
   logic                  dec_q, dec_d;
   logic                  in_ready_q, in_ready_d;
   logic                  out_valid_q, out_valid_d;

   logic [DES_HALF_W-1:0] f_a, r_step1, l_new, r_new;

   des_feistel_f u_f_a (
      .r_in  (r_q),
      .k_in  (subkey),
      .f_out (f_a)
   );

   assign r_step1 = l_q ^ f_a;

`ifdef DES_ROUND_UNROLL2_EN
   logic [DES_HALF_W-1:0] f_b;

   // Second round consumes the first round's output within the same clock.
   des_feistel_f u_f_b (
      .r_in  (r_step1),
      .k_in  (subkey_b),
      .f_out (f_b)
   );

   assign l_new = r_step1;
   assign r_new = r_q ^ f_b;
`else
   assign l_new = r_q;
   assign r_new = r_step1;
`endif

   // Next-state, datapath and handshake decode.
   always_comb begin
      state_d     = state_q;
      l_d         = l_q;
      r_d         = r_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      dec_d       = dec_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               l_d        = data_in[63:32];
               r_d        = data_in[31:0];
               dec_d      = decrypt;
               cnt_d      = 4'd0;
               idx_d      = decrypt ? IDX_TOP : 4'd0;
               in_ready_d = 1'b0;
               state_d    = ST_ROUND;
            end
         end
         ST_ROUND: begin
            l_d   = l_new;
            r_d   = r_new;
            cnt_d = cnt_q + 4'd1;
            idx_d = dec_q ? (idx_q - IDX_STEP) : (idx_q + IDX_STEP);
            if (cnt_q == CNT_LAST) begin
               idx_d       = 4'd0;
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            idx_d       = 4'd0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State, L/R and handshake registers; reset discards any partial block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         l_q         <= '0;
         r_q         <= '0;
         cnt_q       <= 4'd0;
         idx_q       <= 4'd0;
         dec_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         l_q         <= l_d;
         r_q         <= r_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         dec_q       <= dec_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign round_idx = idx_q;
   assign data_out  = {r_q, l_q};

endmodule
